conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/2, constraint-length-7 convolutional encoder (generators 171/133 octal) sitting directly downstream of the PRBS randomizer in the transmit chain. Consumes the randomizer's scrambled bit stream one bit per cycle, emits one coded dibit per input bit, and terminates each frame with six zero tail bits. During the tail it stalls upstream, so the encoder state returns to zero at every frame boundary.

## Interface
- `TAIL_EN`, default 1: when 1, append 6 zero tail bits after `in_last`. When 0, close the frame with no tail and force the state to zero.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_bit` input 1: scrambled data bit from the randomizer.
- `in_valid` input 1: `in_bit` is valid this cycle.
- `in_last` input 1: qualifies `in_bit` as the final data bit of the frame.
- `in_ready` output 1: the encoder accepts `in_bit` this cycle. Upstream advances its own state only when both `in_valid` and `in_ready` are high.
- `out_data` output 2: coded dibit {X, Y}. X comes from G1 = 171 octal, Y from G2 = 133 octal.
- `out_valid` output 1: `out_data` holds a valid dibit.
- `out_last` output 1: marks the final dibit of the frame.
- `out_ready` input 1: the downstream stage accepts `out_data` this cycle.

## Operation
- Shift register `s[5:0]` holds past inputs; `s[0]` is the most recent.
  - X = b ^ s0 ^ s1 ^ s2 ^ s5
  - Y = b ^ s1 ^ s2 ^ s4 ^ s5
  - After each step, `s <= {s[4:0], b}`.
- FSM states: IDLE, DATA, TAIL.
  - IDLE → DATA on the first accepted bit. Any accepted bit encodes immediately, including in IDLE.
  - DATA stays in DATA for each accepted bit with `in_last` = 0.
  - An accepted bit with `in_last` = 1 moves to TAIL if `TAIL_EN` = 1. Otherwise it moves to IDLE, that dibit carries `out_last`, and `s` clears to 0.
  - TAIL encodes b = 0 on each cycle where the output slot is free. A 3-bit counter runs 0..5. The dibit for count 5 carries `out_last`, then the FSM returns to IDLE with `s` = 0.
- `in_ready` = (state != TAIL) && (!out_valid || out_ready).
- A single registered output stage holds `out_data`/`out_valid`/`out_last`.
  - The stage loads when an encode step occurs.
  - It holds stable while `out_valid` = 1 and `out_ready` = 0.
  - `out_valid` clears when the dibit is taken and no new step occurs.
- `in_valid` and `in_last` while in TAIL are ignored, because `in_ready` is 0.
- One-bit frame (`in_last` on the first bit): 1 data dibit + 6 tail dibits.
- Reset (asynchronous, active-low, any time, including mid-frame or mid-tail):
  - state = IDLE, `s` = 0, tail counter = 0
  - `out_valid` = 0, `out_last` = 0, `out_data` = 2'b00
  - `in_ready` is 1 once reset is released
  - A partially sent frame is dropped; there is no partial tail.

## Timing
- Latency: an input accepted at edge N appears as `out_data` valid after edge N (registered), i.e. 1 cycle.
- Throughput: 1 dibit per cycle when `out_ready` is held high. With no backpressure, a frame of L bits takes L + 6 output cycles when `TAIL_EN` = 1.
- The tail occupies exactly 6 output handshakes. `in_ready` rises in the cycle after the `out_last` dibit is loaded into the output stage.
- Backpressure: `out_ready` low freezes the encoder, the output stage, and the tail counter. No dibit is lost or duplicated.
- Simultaneous `out_ready` and a new step: the old dibit is taken and the new dibit loads on the same edge.

## Structure
- Shared package `conv_pkg`:
  - `K` = 7
  - `G1` = 7'o171, `G2` = 7'o133
  - `TAIL_LEN` = 6
  - state enum {IDLE, DATA, TAIL}
- Sub-module `conv_enc_core`: `s` register plus generator XOR trees, with a step enable, a clear, and the b input. The top level holds the FSM, tail counter, and output stage.

## Test plan
- Impulse: from reset, bit 1 with `in_last`, then tail, `out_ready` = 1. Required dibits in order: 11, 10, 11, 11, 00, 01, 11. `out_last` is high on the 7th dibit only.
- All-zero frame of 20 bits: 26 dibits, all 00. `in_ready` is low for exactly 6 cycles after `in_last` is accepted.
- Random 200-bit frame with random `out_ready` (50% duty): output matches the reference-model encoding. `out_data` stays stable whenever it is stalled. Dibit count is 206.
- Back-to-back frames: frame 2 encodes as if from zero state. `TAIL_EN` = 0 variant: `out_last` lands on the last data dibit, and the next frame's first bit 1 gives 11.
- Reset asserted during the 3rd tail cycle: outputs go to 0 immediately. After release, `in_ready` = 1, and a new impulse frame reproduces the first scenario exactly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, state type and generator tap helper for the K=7, rate-1/2 convolutional encoder.
package conv_pkg;

  localparam int K        = 7;
  localparam int TAIL_LEN = 6;

  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o133;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_e;

  // Tap vector MSB is the incoming bit, followed by s[0] (newest) down to s[5] (oldest).
  function automatic logic gen_parity(input logic [K-1:0] g, input logic b,
                                      input logic [K-2:0] s);
    logic [K-1:0] tap;
    tap[K-1] = b;
    for (int i = 0; i < K - 1; i++) begin
      tap[K-2-i] = s[i];
    end
    return ^(tap & g);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and G1/G2 parity trees; advances only on step, optionally clearing to zero.
module conv_enc_core
  import conv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step_i,
  input  logic clr_i,
  input  logic b_i,
  output logic x_o,
  output logic y_o
);

  logic [K-2:0] s_q;

  assign x_o = gen_parity(G1, b_i, s_q);
  assign y_o = gen_parity(G2, b_i, s_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
    end else if (step_i) begin
      s_q <= clr_i ? '0 : {s_q[K-3:0], b_i};
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder with frame tail termination and a single registered output stage.
module conv_encoder
  import conv_pkg::*;
#(
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [1:0]  out_data_q;
  logic        out_valid_q;
  logic        out_last_q;

  logic slot_free;
  logic accept;
  logic tail_step;
  logic step;
  logic enc_b;
  logic frame_end;
  logic x;
  logic y;

  // A new dibit may be produced whenever the output stage is empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != TAIL) && slot_free;
  assign accept    = in_valid && in_ready;
  assign tail_step = (state_q == TAIL) && slot_free;
  assign step      = accept || tail_step;
  assign enc_b     = tail_step ? 1'b0 : in_bit;
  assign frame_end = (accept && in_last && !TAIL_EN) ||
                     (tail_step && (cnt_q == 3'(TAIL_LEN - 1)));

  conv_enc_core u_core (
    .clk    (clk),
    .reset  (reset),
    .step_i (step),
    .clr_i  (frame_end),
    .b_i    (enc_b),
    .x_o    (x),
    .y_o    (y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DATA: begin
          if (accept) begin
            if (in_last) begin
              state_q <= TAIL_EN ? TAIL : IDLE;
              cnt_q   <= '0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        TAIL: begin
          if (tail_step) begin
            if (cnt_q == 3'(TAIL_LEN - 1)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (step) begin
        out_data_q  <= {x, y};
        out_valid_q <= 1'b1;
        out_last_q  <= frame_end;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: impulse, zero frame, random backpressure, back-to-back, no-tail and mid-tail reset.
module tb_conv_encoder;

  typedef struct packed {
    logic b;
    logic last;
  } in_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       sel = 1'b0;

  logic       in_ready1, out_valid1, out_last1;
  logic [1:0] out_data1;
  logic       in_ready0, out_valid0, out_last0;
  logic [1:0] out_data0;

  logic       in_ready_m, out_valid_m, out_last_m;
  logic [1:0] out_data_m;

  int checks = 0;
  int errors = 0;

  in_t        sq[$];
  logic [2:0] cap[$];
  logic [2:0] expq[$];
  logic       fb[$];
  int         low_rdy;
  int         stall_bad;

  always #5 clk = ~clk;

  conv_encoder #(.TAIL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_last(out_last1), .out_ready(out_ready)
  );

  conv_encoder #(.TAIL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_last(out_last0), .out_ready(out_ready)
  );

  assign in_ready_m  = sel ? in_ready0  : in_ready1;
  assign out_valid_m = sel ? out_valid0 : out_valid1;
  assign out_last_m  = sel ? out_last0  : out_last1;
  assign out_data_m  = sel ? out_data0  : out_data1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid_m), 32'd0);
    chk("rst_last",  32'(out_last_m),  32'd0);
    chk("rst_data",  32'(out_data_m),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_inrdy", 32'(in_ready_m), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Reference encoding of the bits in fb, appended to expq; fb is also queued as stimulus.
  task automatic model_frame(input bit tail_en);
    logic [5:0] s;
    logic       b, x, y, last;
    s = '0;
    for (int i = 0; i < fb.size(); i++) begin
      b    = fb[i];
      x    = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      y    = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      last = !tail_en && (i == fb.size() - 1);
      expq.push_back({last, x, y});
      sq.push_back('{b: b, last: (i == fb.size() - 1)});
      s = {s[4:0], b};
    end
    if (tail_en) begin
      for (int t = 0; t < 6; t++) begin
        x = s[0] ^ s[1] ^ s[2] ^ s[5];
        y = s[1] ^ s[2] ^ s[4] ^ s[5];
        expq.push_back({(t == 5), x, y});
        s = {s[4:0], 1'b0};
      end
    end
    fb.delete();
  endtask

  task automatic run(input int budget, input int n_last, input bit rand_rdy);
    int   lasts;
    int   cyc;
    logic prev_stall;
    logic [1:0] prev_data;
    lasts = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 2'b00;
    low_rdy = 0;
    stall_bad = 0;
    cap.delete();
    while (lasts < n_last && cyc < budget) begin
      in_valid = (sq.size() > 0);
      if (sq.size() > 0) begin
        in_bit  = sq[0].b;
        in_last = sq[0].last;
      end else begin
        in_bit  = 1'b0;
        in_last = 1'b0;
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prev_stall && out_data_m !== prev_data) stall_bad++;
      prev_stall = out_valid_m && !out_ready;
      prev_data  = out_data_m;
      if (!in_ready_m) low_rdy++;
      if (out_valid_m && out_ready) begin
        cap.push_back({out_last_m, out_data_m});
        if (out_last_m) lasts++;
      end
      if (in_valid && in_ready_m) void'(sq.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("frames_done", 32'(lasts), 32'(n_last));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 32'(cap.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      chk(tag, (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD, 32'(expq[i]));
    end
    expq.delete();
  endtask

  task automatic load_impulse();
    expq.delete();
    sq.delete();
    sq.push_back('{b: 1'b1, last: 1'b1});
    expq = '{3'b011, 3'b010, 3'b011, 3'b011, 3'b000, 3'b001, 3'b111};
  endtask

  initial begin
    #2;
    reset_dut();

    // Impulse response with tail
    load_impulse();
    run(100, 1, 1'b0);
    compare("impulse");

    // All-zero 20-bit frame
    for (int i = 0; i < 20; i++) fb.push_back(1'b0);
    model_frame(1'b1);
    for (int i = 0; i < expq.size(); i++) chk("zero_model", 32'(expq[i][1:0]), 32'd0);
    run(200, 1, 1'b0);
    chk("zero_inrdy_low", 32'(low_rdy), 32'd6);
    compare("zero");

    // Random 200-bit frame under random backpressure
    for (int i = 0; i < 200; i++) fb.push_back(1'($urandom_range(0, 1)));
    model_frame(1'b1);
    run(5000, 1, 1'b1);
    chk("rand_stall_stable", 32'(stall_bad), 32'd0);
    compare("rand");

    // Back-to-back: random 10-bit frame then impulse, no reset in between
    for (int i = 0; i < 10; i++) fb.push_back(1'($urandom_range(0, 1)));
    model_frame(1'b1);
    fb.push_back(1'b1);
    model_frame(1'b1);
    run(500, 2, 1'b0);
    compare("b2b");

    // No-tail variant: frame 1,0,1 then single-bit frame 1
    sel = 1'b1;
    reset_dut();
    sq.delete();
    sq.push_back('{b: 1'b1, last: 1'b0});
    sq.push_back('{b: 1'b0, last: 1'b0});
    sq.push_back('{b: 1'b1, last: 1'b1});
    sq.push_back('{b: 1'b1, last: 1'b1});
    expq = '{3'b011, 3'b010, 3'b100, 3'b111};
    run(100, 2, 1'b0);
    compare("notail");
    sel = 1'b0;

    // Reset during the third tail cycle
    reset_dut();
    in_bit = 1'b1;
    in_last = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("tail_inrdy", 32'(in_ready_m), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_m), 32'd0);
    chk("midrst_last",  32'(out_last_m),  32'd0);
    chk("midrst_data",  32'(out_data_m),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_inrdy", 32'(in_ready_m), 32'd1);
    @(posedge clk);
    #1;
    load_impulse();
    run(100, 1, 1'b0);
    compare("impulse2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
